screen_painter: RTL and testbench
=================================

# screen_painter

Downstream pixel stage between `display_game` and the VGA adapter. It multiplexes the game's single-pixel plot stream with a built-in full-screen painter. On `start`, the painter clears all 160×120 pixels to a background colour, optionally draws a one-pixel border on the playfield edge, then pulses `done` and returns to pass-through. The top level uses it for power-up and post-game-over screen clears while `display_game` is held in IDLE (`busy` gates its `start`).

## Interface
- `SCREEN_W`, default 160: horizontal pixels; x range 0..SCREEN_W-1.
- `SCREEN_H`, default 120: vertical pixels; y range 0..SCREEN_H-1.
- `DRAW_BORDER`, default 1: 1 = draw border after clear; 0 = skip border phases.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a paint; sampled in IDLE only.
- `bg_colour`  in  3  clear colour; sampled at `start` acceptance.
- `border_colour`  in  3  border colour; sampled at `start` acceptance.
- `game_x`  in  8  pixel x from game.
- `game_y`  in  7  pixel y from game.
- `game_colour`  in  3  pixel colour from game.
- `game_plot`  in  1  game plot strobe.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when painting completes.
- `vga_x`  out  8  pixel x to adapter.
- `vga_y`  out  7  pixel y to adapter.
- `vga_colour`  out  3  pixel colour to adapter.
- `vga_plot`  out  1  plot strobe to adapter.

## Operation
- **FSM states:** IDLE, CLEAR, BORDER_TOP, BORDER_BOTTOM, BORDER_LEFT, BORDER_RIGHT, DONE.
- **IDLE:** combinational pass-through, `vga_*` = `game_*`.
  - `start`=1 latches colours, zeroes x/y counters and enters CLEAR.
- **CLEAR:** plots (x,y) in `bg_colour`, one pixel per cycle, `vga_plot`=1.
  - x is the inner loop and y the outer loop: (0,0),(1,0)…(159,0),(0,1)…(159,119).
  - After (159,119): go to BORDER_TOP if `DRAW_BORDER`=1, else DONE.
- **BORDER_TOP:** x 0..159 at y=0.
- **BORDER_BOTTOM:** x 0..159 at y=119.
- **BORDER_LEFT:** y 1..118 at x=0.
- **BORDER_RIGHT:** y 1..118 at x=159. Then go to DONE.
  - All four border phases plot in the latched `border_colour`.
- **DONE:** `done`=1, `vga_plot`=0, next state IDLE.
- **Game pixels in non-IDLE states** are dropped, not queued. `vga_*` reflects only the painter.
- **`start` while busy:** ignored. A new `start` in the DONE cycle is also ignored; it is accepted in IDLE only.
- **Counter widths:** x counter 8 bits, y counter 7 bits.
  - Terminal compares use `SCREEN_W-1` and `SCREEN_H-1`; no wrap beyond them.
  - Counters reset to 0 on every phase entry.
- **Reset, including mid-paint:**
  - State goes to IDLE; `busy`=0, `done`=0; counters 0; latched colours 3'b000.
  - `vga_*` then equal `game_*`, because IDLE is pass-through.
  - No partial-paint completion and no `done` pulse.

## Timing
- **Registered vs combinational:** `done` and state are registered. `vga_*` and `busy` are combinational from state, counters and game inputs.
- **Acceptance:** `start` is sampled at edge E0. The first pixel (0,0) appears in the cycle after E0.
- **Clear:** 19200 cycles.
- **Border:** 160+160+118+118 = 556 cycles.
- **`done` position:** `done` is high in the cycle after the last plotted pixel.
  - Cycle 19757 after E0 with `DRAW_BORDER`=1.
  - Cycle 19201 with `DRAW_BORDER`=0.
- **`busy`:** high from the cycle after E0 through the DONE cycle inclusive.
- **Return to pass-through:** the cycle after DONE.
- **Plot rate:** exactly one `vga_plot` per cycle in painting states. No gaps; no backpressure exists.

## Structure
- **Shared package `screen_pkg`:**
  - `SCREEN_W`, `SCREEN_H`.
  - Coordinate typedefs `xcoord_t` (logic [7:0]) and `ycoord_t` (logic [6:0]).
  - Colour constants BLACK=3'b000, RED=3'b100, WHITE=3'b111.
  - `painter_state_e` enum.
  - `display_game` and the top level use the same package.
- **Sub-module `xy_sweep`:** a reusable x/y raster counter with `clr`, `en`, and `x_last`/`y_last`/`wrap` flags. It drives CLEAR, while the border phases reuse its x or y counter alone.

## Test plan
- **Reset pass-through:** reset, then `game_plot`=1, `game_x`=20, `game_y`=15, `game_colour`=3'b010 → `vga_*` identical the same cycle; `busy`=0, `done`=0.
- **Full clear, no border:** `DRAW_BORDER`=0, `start` with `bg_colour`=3'b000.
  - 19200 consecutive plots, the first (0,0) and the last (159,119), all colour 0.
  - `done` pulse at cycle 19201; scoreboard confirms every pixel is hit exactly once.
- **Border:** `DRAW_BORDER`=1, `border_colour`=3'b111.
  - Pixels (0,0), (159,0), (0,119) and (159,119) are written white.
  - (1,1) stays `bg_colour`.
  - Exactly 556 border plots; `done` at cycle 19757.
- **Game input while busy:** `game_plot` held high with (50,50,3'b100) during painting → never appears on `vga_*`. It appears in the cycle after DONE.
- **`start` while busy:** `start` re-pulsed at cycle 100 and in the DONE cycle → no restart and a single `done`. A `start` one cycle after DONE is accepted.
- **Reset mid-paint:** `rst_n` deasserted at cycle 5000 → `busy`=0 immediately (asynchronously) and no `done`. A later `start` resumes from (0,0).

Source files
------------

// File: rtl/screen_pkg.sv
// Shared screen geometry, coordinate/colour types and painter state encoding
// used by the painter, display_game and the top level.
package screen_pkg;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    typedef logic [7:0] xcoord_t;
    typedef logic [6:0] ycoord_t;
    typedef logic [2:0] colour_t;

    localparam colour_t BLACK = 3'b000;
    localparam colour_t RED   = 3'b100;
    localparam colour_t WHITE = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        BORDER_TOP,
        BORDER_BOTTOM,
        BORDER_LEFT,
        BORDER_RIGHT,
        DONE
    } painter_state_e;
endpackage

// File: rtl/screen_painter_if.sv
// Pixel streams around the painter: game plot stream in, VGA adapter stream out.
interface screen_painter_if;
    import screen_pkg::*;

    xcoord_t game_x;
    ycoord_t game_y;
    colour_t game_colour;
    logic    game_plot;

    xcoord_t vga_x;
    ycoord_t vga_y;
    colour_t vga_colour;
    logic    vga_plot;

    // master: the side producing game pixels and consuming the VGA stream
    modport master (
        output game_x, game_y, game_colour, game_plot,
        input  vga_x, vga_y, vga_colour, vga_plot
    );

    modport slave (
        input  game_x, game_y, game_colour, game_plot,
        output vga_x, vga_y, vga_colour, vga_plot
    );
endinterface

// File: rtl/screen_painter_xy_sweep.sv
// Raster counter: x inner, y outer when chained; either axis can also step alone.
module xy_sweep #(
    parameter int X_LAST = 159,
    parameter int Y_LAST = 119
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                x_en,
    input  logic                y_en,
    input  logic                chain,
    output screen_pkg::xcoord_t x,
    output screen_pkg::ycoord_t y,
    output logic                x_last,
    output logic                y_last,
    output logic                wrap
);
    import screen_pkg::*;

    localparam xcoord_t X_MAX = xcoord_t'(X_LAST);
    localparam ycoord_t Y_MAX = ycoord_t'(Y_LAST);

    xcoord_t x_reg;
    ycoord_t y_reg;

    assign x      = x_reg;
    assign y      = y_reg;
    assign x_last = (x_reg == X_MAX);
    assign y_last = (y_reg == Y_MAX);
    // x is about to roll over to the next row this cycle
    assign wrap   = x_en && x_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg <= '0;
            y_reg <= '0;
        end else if (clr) begin
            x_reg <= '0;
            y_reg <= '0;
        end else begin
            if (x_en) begin
                x_reg <= x_last ? '0 : x_reg + 8'd1;
            end
            if (y_en && (!chain || x_last)) begin
                y_reg <= y_last ? '0 : y_reg + 7'd1;
            end
        end
    end
endmodule

// File: rtl/screen_painter.sv
// Pixel multiplexer: passes game plots through when idle, otherwise runs a
// full-screen clear followed by an optional one-pixel playfield border.
module screen_painter #(
    parameter int SCREEN_W    = screen_pkg::SCREEN_W,
    parameter int SCREEN_H    = screen_pkg::SCREEN_H,
    parameter int DRAW_BORDER = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  screen_pkg::colour_t bg_colour,
    input  screen_pkg::colour_t border_colour,
    output logic                busy,
    output logic                done,
    screen_painter_if.slave     pix
);
    import screen_pkg::*;

    localparam xcoord_t X_MAX       = xcoord_t'(SCREEN_W - 1);
    localparam ycoord_t Y_MAX       = ycoord_t'(SCREEN_H - 1);
    // side borders cover y 1..H-2, so the counter runs 0..H-3 with a +1 offset
    localparam ycoord_t Y_SIDE_LAST = ycoord_t'(SCREEN_H - 3);

    painter_state_e state_reg;
    colour_t        bg_reg;
    colour_t        border_reg;
    logic           done_reg;

    xcoord_t sx;
    ycoord_t sy;
    logic    x_last, y_last, wrap;
    logic    sweep_clr, x_en, y_en, chain, phase_end, side_last;

    xy_sweep #(
        .X_LAST (SCREEN_W - 1),
        .Y_LAST (SCREEN_H - 1)
    ) u_sweep (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (sweep_clr),
        .x_en   (x_en),
        .y_en   (y_en),
        .chain  (chain),
        .x      (sx),
        .y      (sy),
        .x_last (x_last),
        .y_last (y_last),
        .wrap   (wrap)
    );

    always_comb begin
        x_en      = 1'b0;
        y_en      = 1'b0;
        chain     = 1'b0;
        phase_end = 1'b0;
        side_last = (sy == Y_SIDE_LAST);
        case (state_reg)
            CLEAR: begin
                x_en      = 1'b1;
                y_en      = 1'b1;
                chain     = 1'b1;
                phase_end = wrap && y_last;
            end
            BORDER_TOP, BORDER_BOTTOM: begin
                x_en      = 1'b1;
                phase_end = x_last;
            end
            BORDER_LEFT, BORDER_RIGHT: begin
                y_en      = 1'b1;
                phase_end = side_last;
            end
            default: ;
        endcase
        // counters restart from zero on every phase entry
        sweep_clr = (state_reg == IDLE) || phase_end;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            bg_reg     <= BLACK;
            border_reg <= BLACK;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg  <= CLEAR;
                        bg_reg     <= bg_colour;
                        border_reg <= border_colour;
                    end
                end
                CLEAR: begin
                    if (phase_end) begin
                        if (DRAW_BORDER != 0) begin
                            state_reg <= BORDER_TOP;
                        end else begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                BORDER_TOP: begin
                    if (phase_end) state_reg <= BORDER_BOTTOM;
                end
                BORDER_BOTTOM: begin
                    if (phase_end) state_reg <= BORDER_LEFT;
                end
                BORDER_LEFT: begin
                    if (phase_end) state_reg <= BORDER_RIGHT;
                end
                BORDER_RIGHT: begin
                    if (phase_end) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                    end
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_comb begin
        pix.vga_x      = sx;
        pix.vga_y      = sy;
        pix.vga_colour = bg_reg;
        pix.vga_plot   = 1'b1;
        case (state_reg)
            IDLE: begin
                pix.vga_x      = pix.game_x;
                pix.vga_y      = pix.game_y;
                pix.vga_colour = pix.game_colour;
                pix.vga_plot   = pix.game_plot;
            end
            BORDER_TOP: begin
                pix.vga_y      = '0;
                pix.vga_colour = border_reg;
            end
            BORDER_BOTTOM: begin
                pix.vga_y      = Y_MAX;
                pix.vga_colour = border_reg;
            end
            BORDER_LEFT: begin
                pix.vga_x      = '0;
                pix.vga_y      = sy + 7'd1;
                pix.vga_colour = border_reg;
            end
            BORDER_RIGHT: begin
                pix.vga_x      = X_MAX;
                pix.vga_y      = sy + 7'd1;
                pix.vga_colour = border_reg;
            end
            DONE: begin
                pix.vga_x      = '0;
                pix.vga_y      = '0;
                pix.vga_colour = BLACK;
                pix.vga_plot   = 1'b0;
            end
            default: ;
        endcase
    end

    assign busy = (state_reg != IDLE);
    assign done = done_reg;
endmodule

// File: tb/tb_screen_painter.sv
// Scoreboard bench for screen_painter: one instance without border, one with.
module tb_screen_painter;
    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic       start_nb = 1'b0, start_b = 1'b0;
    logic [2:0] bg_nb = 3'b000, bd_nb = 3'b000, bg_b = 3'b000, bd_b = 3'b000;
    logic       busy_nb, done_nb, busy_b, done_b;

    screen_painter_if if_nb ();
    screen_painter_if if_b ();

    screen_painter #(.DRAW_BORDER(0)) u_nb (
        .clk (clk), .rst_n (rst_n), .start (start_nb),
        .bg_colour (bg_nb), .border_colour (bd_nb),
        .busy (busy_nb), .done (done_nb), .pix (if_nb)
    );

    screen_painter #(.DRAW_BORDER(1)) u_b (
        .clk (clk), .rst_n (rst_n), .start (start_b),
        .bg_colour (bg_b), .border_colour (bd_b),
        .busy (busy_b), .done (done_b), .pix (if_b)
    );

    pix_t q_nb[$];
    pix_t q_b[$];
    int   plots_nb = 0, plots_b = 0;
    int   done_cnt_nb = 0, done_cnt_b = 0;
    int   done_cyc_nb = 0, done_cyc_b = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_pix(input string name, input pix_t act, input pix_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got (%0d,%0d,c%0d), expected (%0d,%0d,c%0d)",
                     name, act.x, act.y, act.c, exp.x, exp.y, exp.c);
        end
    endtask

    task automatic push(input bit to_b, input int x, input int y, input logic [2:0] c);
        pix_t p;
        p.x = 8'(x);
        p.y = 7'(y);
        p.c = c;
        if (to_b) q_b.push_back(p);
        else      q_nb.push_back(p);
    endtask

    task automatic push_clear(input bit to_b, input logic [2:0] c);
        for (int y = 0; y < 120; y++)
            for (int x = 0; x < 160; x++)
                push(to_b, x, y, c);
    endtask

    task automatic push_border(input logic [2:0] c);
        for (int x = 0; x < 160; x++) push(1'b1, x, 0, c);
        for (int x = 0; x < 160; x++) push(1'b1, x, 119, c);
        for (int y = 1; y < 119; y++) push(1'b1, 0, y, c);
        for (int y = 1; y < 119; y++) push(1'b1, 159, y, c);
    endtask

    task automatic set_game(input int x, input int y, input logic [2:0] c, input logic p);
        if_nb.game_x = 8'(x); if_nb.game_y = 7'(y); if_nb.game_colour = c; if_nb.game_plot = p;
        if_b.game_x  = 8'(x); if_b.game_y  = 7'(y); if_b.game_colour  = c; if_b.game_plot  = p;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input bit on_b, input int prev, input string name);
        int n = 0;
        while (((on_b ? done_cnt_b : done_cnt_nb) == prev) && n < 25000) begin
            tick();
            n++;
        end
        if ((on_b ? done_cnt_b : done_cnt_nb) == prev) begin
            checks++;
            errors++;
            $display("FAIL %s: no done within %0d cycles", name, n);
        end
    endtask

    // monitors: pop one expected pixel per painter plot, track done pulses
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy_nb && !done_nb) chk("plot_gap_nb", int'(if_nb.vga_plot), 1);
            if (busy_nb && if_nb.vga_plot) begin
                if (q_nb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_plot_nb: got (%0d,%0d), expected no plot",
                             if_nb.vga_x, if_nb.vga_y);
                end else begin
                    chk_pix("pixel_nb", {if_nb.vga_x, if_nb.vga_y, if_nb.vga_colour},
                            q_nb.pop_front());
                    plots_nb++;
                end
            end
            if (done_nb) begin
                done_cnt_nb++;
                done_cyc_nb = cyc;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (busy_b && !done_b) chk("plot_gap_b", int'(if_b.vga_plot), 1);
            if (busy_b && if_b.vga_plot) begin
                if (q_b.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_plot_b: got (%0d,%0d), expected no plot",
                             if_b.vga_x, if_b.vga_y);
                end else begin
                    chk_pix("pixel_b", {if_b.vga_x, if_b.vga_y, if_b.vga_colour},
                            q_b.pop_front());
                    plots_b++;
                end
            end
            if (done_b) begin
                done_cnt_b++;
                done_cyc_b = cyc;
            end
        end
    end

    initial begin
        int e0, e1, e2;
        set_game(20, 15, 3'b010, 1'b1);
        repeat (3) tick();
        rst_n = 1'b1;

        // reset pass-through
        @(negedge clk);
        chk("pass_x_nb", int'(if_nb.vga_x), 20);
        chk("pass_y_nb", int'(if_nb.vga_y), 15);
        chk("pass_c_nb", int'(if_nb.vga_colour), 2);
        chk("pass_plot_nb", int'(if_nb.vga_plot), 1);
        chk("pass_x_b", int'(if_b.vga_x), 20);
        chk("pass_c_b", int'(if_b.vga_colour), 2);
        chk("reset_busy", int'({busy_nb, busy_b}), 0);
        chk("reset_done", int'({done_nb, done_b}), 0);

        // full clear without border, game pixel held throughout
        tick();
        set_game(50, 50, 3'b100, 1'b1);
        push_clear(1'b0, 3'b000);
        bg_nb = 3'b000;
        bd_nb = 3'b101;
        start_nb = 1'b1;
        tick();
        start_nb = 1'b0;
        e0 = cyc;
        bg_nb = 3'b111;
        $display("nb: paint accepted at cycle %0d", e0);
        wait_done(1'b0, 0, "done_nb_timeout");
        chk("done_cycle_nb", done_cyc_nb - e0 + 1, 19201);
        chk("done_count_nb", done_cnt_nb, 1);
        chk("plots_nb", plots_nb, 19200);
        chk("queue_left_nb", q_nb.size(), 0);
        @(negedge clk);
        chk("after_done_busy_nb", int'(busy_nb), 0);
        chk("after_done_x_nb", int'(if_nb.vga_x), 50);
        chk("after_done_y_nb", int'(if_nb.vga_y), 50);
        chk("after_done_c_nb", int'(if_nb.vga_colour), 4);
        chk("after_done_plot_nb", int'(if_nb.vga_plot), 1);

        // clear plus white border, start re-pulsed at cycle 100 and in DONE
        tick();
        push_clear(1'b1, 3'b001);
        push_border(3'b111);
        bg_b = 3'b001;
        bd_b = 3'b111;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        e0 = cyc;
        bg_b = 3'b010;
        bd_b = 3'b011;
        $display("b: paint accepted at cycle %0d", e0);
        repeat (99) tick();
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        repeat (19656) tick();
        start_b = 1'b1;
        tick();
        chk("done_count_b", done_cnt_b, 1);
        chk("done_cycle_b", done_cyc_b - e0 + 1, 19757);
        chk("plots_b", plots_b, 19756);
        chk("queue_left_b", q_b.size(), 0);
        chk("idle_after_done_b", int'(busy_b), 0);

        // start held one cycle past DONE is accepted
        bg_b = 3'b101;
        push_clear(1'b1, 3'b101);
        tick();
        start_b = 1'b0;
        e1 = cyc;
        $display("b: second paint accepted at cycle %0d", e1);
        @(negedge clk);
        chk("restart_busy_b", int'(busy_b), 1);

        // asynchronous reset in cycle 5000 of the second paint
        repeat (4999) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_busy_b", int'(busy_b), 0);
        chk("midreset_done_b", int'(done_b), 0);
        chk("midreset_pass_x_b", int'(if_b.vga_x), 50);
        chk("midreset_plots_b", plots_b, 19756 + 4999);
        q_b.delete();
        tick();
        rst_n = 1'b1;
        repeat (20) tick();
        chk("no_done_after_reset_b", done_cnt_b, 1);
        chk("idle_after_reset_b", int'(busy_b), 0);

        // fresh paint restarts from (0,0)
        push_clear(1'b1, 3'b110);
        push_border(3'b001);
        bg_b = 3'b110;
        bd_b = 3'b001;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        e2 = cyc;
        $display("b: third paint accepted at cycle %0d", e2);
        wait_done(1'b1, 1, "done_b_timeout");
        chk("done_cycle_b2", done_cyc_b - e2 + 1, 19757);
        chk("done_count_b2", done_cnt_b, 2);
        chk("queue_left_b2", q_b.size(), 0);
        @(negedge clk);
        chk("after_done_x_b", int'(if_b.vga_x), 50);
        chk("after_done_c_b", int'(if_b.vga_colour), 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
